// File: rtl/rvlab_jtag_dtm.sv
// rtl/rvlab_jtag_dtm.sv - RISC-V debug transport module with a clk-oversampled JTAG TAP
// Provides IDCODE/DTMCS/DMI/BYPASS and turns DMI scans into a valid/ready request/response port.
module rvlab_jtag_dtm #(
    parameter logic [31:0] IDCODE    = 32'h249511C3,
    parameter int          ABITS     = 7,
    parameter int          IDLE_HINT = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             jtag_tck_i,
    input  logic             jtag_tms_i,
    input  logic             jtag_tdi_i,
    input  logic             jtag_trst_ni,
    output logic             jtag_tdo_o,
    output logic             dmi_req_valid_o,
    input  logic             dmi_req_ready_i,
    output logic [ABITS-1:0] dmi_req_addr_o,
    output logic [1:0]       dmi_req_op_o,
    output logic [31:0]      dmi_req_data_o,
    input  logic             dmi_rsp_valid_i,
    output logic             dmi_rsp_ready_o,
    input  logic [31:0]      dmi_rsp_data_i,
    input  logic [1:0]       dmi_rsp_resp_i,
    output logic             dmi_hardreset_o
);

    localparam int         DMI_W     = ABITS + 34;
    localparam logic [4:0] IR_IDCODE = 5'h01;
    localparam logic [4:0] IR_DTMCS  = 5'h10;
    localparam logic [4:0] IR_DMI    = 5'h11;

    typedef enum logic [3:0] {
        TEST_LOGIC_RESET, RUN_TEST_IDLE,
        SELECT_DR, CAPTURE_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPDATE_DR,
        SELECT_IR, CAPTURE_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPDATE_IR
    } tap_state_e;

    logic [1:0] tck_sync, tms_sync, tdi_sync, trst_sync;
    logic       tck_prev;
    logic       tck_rise, tck_fall, tms, tdi, tap_rst;

    tap_state_e state, state_next;
    logic capture_dr, shift_dr, update_dr, capture_ir, shift_ir, update_ir;

    logic [4:0]       ir, ir_sr;
    logic             sel_idcode, sel_dtmcs, sel_dmi;
    logic [DMI_W-1:0] dr_sr, dr_shifted, dr_capture;
    logic [31:0]      dtmcs_value;

    logic             busy, req_valid, hardreset, tdo;
    logic [1:0]       sticky, sticky_eff, req_op;
    logic [ABITS-1:0] last_addr, req_addr;
    logic [31:0]      last_data, req_data;
    logic             rsp_fire, busy_eff, dr_update;
    logic [1:0]       upd_op;
    logic [31:0]      upd_data;
    logic [ABITS-1:0] upd_addr;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tck_sync  <= '0;
            tms_sync  <= '0;
            tdi_sync  <= '0;
            trst_sync <= '0;
            tck_prev  <= 1'b0;
        end else begin
            tck_sync  <= {tck_sync[0], jtag_tck_i};
            tms_sync  <= {tms_sync[0], jtag_tms_i};
            tdi_sync  <= {tdi_sync[0], jtag_tdi_i};
            trst_sync <= {trst_sync[0], jtag_trst_ni};
            tck_prev  <= tck_sync[1];
        end
    end

    assign tck_rise = tck_sync[1] & ~tck_prev;
    assign tck_fall = ~tck_sync[1] & tck_prev;
    assign tms      = tms_sync[1];
    assign tdi      = tdi_sync[1];
    assign tap_rst  = rst_i | ~trst_sync[1];

    always_ff @(posedge clk_i) begin
        if (tap_rst) begin
            state <= TEST_LOGIC_RESET;
        end else if (tck_rise) begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            TEST_LOGIC_RESET: state_next = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
            RUN_TEST_IDLE:    state_next = tms ? SELECT_DR : RUN_TEST_IDLE;
            SELECT_DR:        state_next = tms ? SELECT_IR : CAPTURE_DR;
            CAPTURE_DR:       state_next = tms ? EXIT1_DR : SHIFT_DR;
            SHIFT_DR:         state_next = tms ? EXIT1_DR : SHIFT_DR;
            EXIT1_DR:         state_next = tms ? UPDATE_DR : PAUSE_DR;
            PAUSE_DR:         state_next = tms ? EXIT2_DR : PAUSE_DR;
            EXIT2_DR:         state_next = tms ? UPDATE_DR : SHIFT_DR;
            UPDATE_DR:        state_next = tms ? SELECT_DR : RUN_TEST_IDLE;
            SELECT_IR:        state_next = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
            CAPTURE_IR:       state_next = tms ? EXIT1_IR : SHIFT_IR;
            SHIFT_IR:         state_next = tms ? EXIT1_IR : SHIFT_IR;
            EXIT1_IR:         state_next = tms ? UPDATE_IR : PAUSE_IR;
            PAUSE_IR:         state_next = tms ? EXIT2_IR : PAUSE_IR;
            EXIT2_IR:         state_next = tms ? UPDATE_IR : SHIFT_IR;
            UPDATE_IR:        state_next = tms ? SELECT_DR : RUN_TEST_IDLE;
            default:          state_next = TEST_LOGIC_RESET;
        endcase
    end

    always_comb begin
        capture_dr = (state == CAPTURE_DR);
        shift_dr   = (state == SHIFT_DR);
        update_dr  = (state == UPDATE_DR);
        capture_ir = (state == CAPTURE_IR);
        shift_ir   = (state == SHIFT_IR);
        update_ir  = (state == UPDATE_IR);
    end

    always_ff @(posedge clk_i) begin
        if (tap_rst) begin
            ir    <= IR_IDCODE;
            ir_sr <= 5'b00001;
        end else if (tck_rise) begin
            if (capture_ir) ir_sr <= 5'b00001;
            if (shift_ir)   ir_sr <= {tdi, ir_sr[4:1]};
            if (update_ir)  ir    <= ir_sr;
            if (state_next == TEST_LOGIC_RESET) ir <= IR_IDCODE;
        end
    end

    assign sel_idcode  = (ir == IR_IDCODE);
    assign sel_dtmcs   = (ir == IR_DTMCS);
    assign sel_dmi     = (ir == IR_DMI);
    assign dtmcs_value = {17'd0, 3'(IDLE_HINT), sticky, 6'(ABITS), 4'd1};

    // Shorter registers share the low bits of one shift register; TDI enters at the selected length.
    always_comb begin
        dr_shifted = {1'b0, dr_sr[DMI_W-1:1]};
        if (sel_dmi) begin
            dr_shifted[DMI_W-1] = tdi;
        end else if (sel_idcode || sel_dtmcs) begin
            dr_shifted[31] = tdi;
        end else begin
            dr_shifted[0] = tdi;
        end
    end

    always_comb begin
        dr_capture = '0;
        if (sel_idcode) begin
            dr_capture[31:0] = IDCODE;
        end else if (sel_dtmcs) begin
            dr_capture[31:0] = dtmcs_value;
        end else if (sel_dmi) begin
            dr_capture = {last_addr, last_data, (busy ? 2'd3 : sticky)};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dr_sr <= '0;
        end else if (tck_rise) begin
            if (capture_dr) begin
                dr_sr <= dr_capture;
            end else if (shift_dr) begin
                dr_sr <= dr_shifted;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (tap_rst) begin
            tdo <= 1'b0;
        end else if (tck_fall) begin
            tdo <= shift_ir ? ir_sr[0] : (shift_dr ? dr_sr[0] : 1'b0);
        end
    end

    assign upd_op    = dr_sr[1:0];
    assign upd_data  = dr_sr[33:2];
    assign upd_addr  = dr_sr[DMI_W-1:34];
    assign rsp_fire  = dmi_rsp_valid_i & dmi_rsp_ready_o;
    assign dr_update = tck_rise & update_dr & ~tap_rst;
    // A response landing in the same clk as an update is accounted for before the update is judged.
    assign busy_eff   = busy & ~rsp_fire;
    assign sticky_eff = (rsp_fire && dmi_rsp_resp_i != 2'd0) ? 2'd2 : sticky;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy      <= 1'b0;
            req_valid <= 1'b0;
            hardreset <= 1'b0;
            sticky    <= 2'd0;
            last_addr <= '0;
            last_data <= '0;
            req_addr  <= '0;
            req_op    <= 2'd0;
            req_data  <= '0;
        end else begin
            hardreset <= 1'b0;
            if (req_valid && dmi_req_ready_i) req_valid <= 1'b0;
            if (rsp_fire) begin
                busy      <= 1'b0;
                last_addr <= req_addr;
                last_data <= (req_op == 2'd1) ? dmi_rsp_data_i : req_data;
                if (dmi_rsp_resp_i != 2'd0) sticky <= 2'd2;
            end
            if (dr_update && sel_dtmcs && (dr_sr[16] || dr_sr[17])) sticky <= 2'd0;
            if (dr_update && sel_dtmcs && dr_sr[17]) begin
                busy      <= 1'b0;
                req_valid <= 1'b0;
                hardreset <= 1'b1;
            end
            if (dr_update && sel_dmi && (upd_op == 2'd1 || upd_op == 2'd2) && sticky_eff == 2'd0) begin
                if (busy_eff) begin
                    sticky <= 2'd3;
                end else begin
                    busy      <= 1'b1;
                    req_valid <= 1'b1;
                    req_addr  <= upd_addr;
                    req_op    <= upd_op;
                    req_data  <= upd_data;
                end
            end
        end
    end

    assign jtag_tdo_o      = tdo;
    assign dmi_req_valid_o = req_valid;
    assign dmi_req_addr_o  = req_addr;
    assign dmi_req_op_o    = req_op;
    assign dmi_req_data_o  = req_data;
    assign dmi_rsp_ready_o = busy & ~req_valid;
    assign dmi_hardreset_o = hardreset;

endmodule

// File: tb/tb_rvlab_jtag_dtm.sv
// tb/tb_rvlab_jtag_dtm.sv - scoreboard bench for rvlab_jtag_dtm driving JTAG pins and a DMI responder
// A transaction-level DMI model predicts scan captures and requests; monitors compare against queues.
module tb_rvlab_jtag_dtm;

    localparam logic [31:0] IDCODE_V = 32'h249511C3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tck = 1'b0, tms = 1'b1, tdi = 1'b0, trst_n = 1'b1;
    logic        tdo;
    logic        req_valid, req_ready = 1'b0;
    logic [6:0]  req_addr;
    logic [1:0]  req_op;
    logic [31:0] req_data;
    logic        rsp_valid = 1'b0, rsp_ready;
    logic [31:0] rsp_data = 32'd0;
    logic [1:0]  rsp_resp = 2'd0;
    logic        hardreset;

    rvlab_jtag_dtm dut (
        .clk_i(clk), .rst_i(rst),
        .jtag_tck_i(tck), .jtag_tms_i(tms), .jtag_tdi_i(tdi), .jtag_trst_ni(trst_n),
        .jtag_tdo_o(tdo),
        .dmi_req_valid_o(req_valid), .dmi_req_ready_i(req_ready),
        .dmi_req_addr_o(req_addr), .dmi_req_op_o(req_op), .dmi_req_data_o(req_data),
        .dmi_rsp_valid_i(rsp_valid), .dmi_rsp_ready_o(rsp_ready),
        .dmi_rsp_data_i(rsp_data), .dmi_rsp_resp_i(rsp_resp),
        .dmi_hardreset_o(hardreset)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct { string name; logic [63:0] val; } exp_t;
    typedef struct { logic [6:0] addr; logic [1:0] op; logic [31:0] data; } req_t;
    exp_t        exp_scan_q[$];
    logic [63:0] obs_scan_q[$];
    req_t        exp_req_q[$];

    // transaction-level DMI model
    logic        m_busy = 1'b0;
    logic [1:0]  m_sticky = 2'd0;
    logic [6:0]  m_last_addr = '0;
    logic [31:0] m_last_data = '0;
    req_t        m_req;
    logic [4:0]  cur_ir = 5'h01;
    int          hr_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) if (hardreset) hr_cnt++;

    exp_t        mon_e;
    logic [63:0] mon_o;
    req_t        mon_r;
    always @(negedge clk) begin
        if (obs_scan_q.size() > 0) begin
            mon_o = obs_scan_q.pop_front();
            if (exp_scan_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_scan: got %0h expected none", mon_o);
            end else begin
                mon_e = exp_scan_q.pop_front();
                check(mon_e.name, mon_o, mon_e.val);
            end
        end
        if (req_valid && req_ready) begin
            if (exp_req_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_req: got addr %0h op %0d data %0h expected none", req_addr, req_op, req_data);
            end else begin
                mon_r = exp_req_q.pop_front();
                check("dmi_req", {23'd0, req_addr, req_op, req_data}, {23'd0, mon_r.addr, mon_r.op, mon_r.data});
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2 req_ready = ($urandom_range(0, 2) == 0);
        end
    end

    initial begin
        #900us;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tck_cycle(input logic tms_v, input logic tdi_v, output logic tdo_v);
        tms = tms_v;
        tdi = tdi_v;
        #40;
        tdo_v = tdo;
        tck = 1'b1;
        #40;
        tck = 1'b0;
    endtask

    task automatic reset_tap();
        logic d;
        repeat (5) tck_cycle(1'b1, 1'b0, d);
        tck_cycle(1'b0, 1'b0, d);
    endtask

    task automatic ir_scan(input logic [4:0] v);
        logic d;
        logic [63:0] cap = '0;
        exp_scan_q.push_back('{"ir_capture", 64'h01});
        tck_cycle(1'b1, 1'b0, d);
        tck_cycle(1'b1, 1'b0, d);
        tck_cycle(1'b0, 1'b0, d);
        tck_cycle(1'b0, 1'b0, d);
        for (int i = 0; i < 5; i++) begin
            tck_cycle(i == 4, v[i], d);
            cap[i] = d;
        end
        tck_cycle(1'b1, 1'b0, d);
        tck_cycle(1'b0, 1'b0, d);
        obs_scan_q.push_back(cap);
        cur_ir = v;
    endtask

    task automatic ensure_ir(input logic [4:0] v);
        if (cur_ir != v) ir_scan(v);
    endtask

    task automatic dr_scan(input int len, input logic [63:0] v, input string name, input logic [63:0] exp);
        logic d;
        logic [63:0] cap = '0;
        exp_scan_q.push_back('{name, exp});
        tck_cycle(1'b1, 1'b0, d);
        tck_cycle(1'b0, 1'b0, d);
        tck_cycle(1'b0, 1'b0, d);
        for (int i = 0; i < len; i++) begin
            tck_cycle(i == len - 1, v[i], d);
            cap[i] = d;
        end
        tck_cycle(1'b1, 1'b0, d);
        tck_cycle(1'b0, 1'b0, d);
        obs_scan_q.push_back(cap);
    endtask

    task automatic dmi_scan(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] data);
        logic [63:0] expc;
        expc = {23'd0, m_last_addr, m_last_data, (m_busy ? 2'd3 : m_sticky)};
        if ((op == 2'd1 || op == 2'd2) && m_sticky == 2'd0) begin
            if (m_busy) begin
                m_sticky = 2'd3;
            end else begin
                m_busy = 1'b1;
                m_req  = '{addr, op, data};
                exp_req_q.push_back(m_req);
            end
        end
        ensure_ir(5'h11);
        dr_scan(41, {23'd0, addr, data, op}, "dmi_capture", expc);
    endtask

    task automatic dtmcs_scan(input logic [31:0] w);
        logic [63:0] expc;
        expc = 64'h1071 | (64'(m_sticky) << 10);
        if (w[16] || w[17]) m_sticky = 2'd0;
        if (w[17]) m_busy = 1'b0;
        ensure_ir(5'h10);
        dr_scan(32, {32'd0, w}, "dtmcs_capture", expc);
    endtask

    task automatic wait_rsp_ready(output bit ok);
        int n = 0;
        while (!rsp_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        ok = rsp_ready;
        if (!ok) begin
            checks++; errors++;
            $display("FAIL rsp_wait: got rsp_ready 0 expected 1");
        end
    endtask

    task automatic respond(input logic [31:0] rd, input logic [1:0] resp);
        bit ok;
        wait_rsp_ready(ok);
        if (ok) begin
            rsp_valid = 1'b1;
            rsp_data  = rd;
            rsp_resp  = resp;
            @(posedge clk);
            #1 rsp_valid = 1'b0;
            m_last_addr = m_req.addr;
            m_last_data = (m_req.op == 2'd1) ? rd : m_req.data;
            if (resp != 2'd0) m_sticky = 2'd2;
            m_busy = 1'b0;
        end
        @(posedge clk);
        #3;
    endtask

    initial begin
        logic d;
        bit ok;
        int hr_base;
        logic [15:0] bp;

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rst_tdo", tdo, 0);
        check("rst_req_valid", req_valid, 0);
        check("rst_hardreset", hardreset, 0);
        check("rst_req_fields", {req_addr, req_op, req_data}, 0);
        check("rst_rsp_ready", rsp_ready, 0);
        @(posedge clk);
        rst = 1'b0;
        #3;

        reset_tap();
        dr_scan(32, {$urandom, $urandom}, "idcode", 64'(IDCODE_V));

        ir_scan(5'h10);
        dtmcs_scan(32'd0);
        ir_scan(5'h1F);
        dr_scan(4, 64'b1101, "bypass_pattern", 64'b1010);
        bp = 16'($urandom);
        dr_scan(16, 64'(bp), "bypass_random", {47'd0, bp[14:0], 1'b0});

        dmi_scan(2'd2, 7'h10, 32'h1);
        respond($urandom, 2'd0);
        dmi_scan(2'd0, 7'h00, 32'h0);
        check("dmi_write_model", {m_last_addr, m_last_data}, {7'h10, 32'h1});

        dmi_scan(2'd1, 7'($urandom), $urandom);
        dmi_scan(2'd1, 7'($urandom), $urandom);
        respond($urandom, 2'd0);
        dmi_scan(2'd0, 7'h00, 32'h0);
        dtmcs_scan(32'h0001_0000);
        dtmcs_scan(32'd0);

        dmi_scan(2'd1, 7'h22, 32'h0);
        respond(32'hDEAD_BEEF, 2'd2);
        dmi_scan(2'd2, 7'h05, $urandom);
        dmi_scan(2'd0, 7'h00, 32'h0);
        dtmcs_scan(32'h0001_0000);

        dmi_scan(2'd1, 7'h33, 32'h0);
        wait_rsp_ready(ok);
        @(posedge clk);
        #3;
        hr_base = hr_cnt;
        dtmcs_scan(32'h0002_0000);
        check("hardreset_pulse", 64'(hr_cnt - hr_base), 1);
        check("hardreset_rsp_ready", rsp_ready, 0);
        dmi_scan(2'd0, 7'h00, 32'h0);

        dmi_scan(2'd1, 7'h44, 32'h0);
        tck_cycle(1'b1, 1'b0, d);
        tck_cycle(1'b0, 1'b0, d);
        tck_cycle(1'b0, 1'b0, d);
        repeat (10) tck_cycle(1'b0, 1'($urandom), d);
        trst_n = 1'b0;
        #100;
        check("trst_tdo", tdo, 0);
        trst_n = 1'b1;
        #80;
        cur_ir = 5'h01;
        tck_cycle(1'b0, 1'b0, d);
        dr_scan(32, {$urandom, $urandom}, "idcode_after_trst", 64'(IDCODE_V));
        respond(32'hCAFE_0001, 2'd0);
        dmi_scan(2'd0, 7'h00, 32'h0);

        for (int it = 0; it < 12; it++) begin
            dmi_scan(2'($urandom_range(1, 2)), 7'($urandom), $urandom);
            if ($urandom_range(0, 3) == 0) dmi_scan(2'($urandom_range(0, 3)), 7'($urandom), $urandom);
            if (m_busy) respond($urandom, ($urandom_range(0, 4) == 0) ? 2'd2 : 2'd0);
            if (m_sticky != 2'd0 && $urandom_range(0, 1) == 1) dtmcs_scan(32'h0001_0000);
        end
        dmi_scan(2'd0, 7'h00, 32'h0);
        dtmcs_scan(32'd0);

        repeat (5) @(negedge clk);
        check("scan_queue_empty", 64'(exp_scan_q.size()), 0);
        check("req_queue_empty", 64'(exp_req_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rvlab_jtag_dtm.md
Name: rvlab_jtag_dtm

Overview:
- RISC-V debug transport module (DTM, debug spec 0.13) for the rvlab board.
- Sits between the board JTAG pins and the debug module.
- JTAG pins are oversampled in the single system clock domain; there is no TCK clock domain.
- Provides IDCODE, DTMCS, DMI and BYPASS data registers, and converts DMI scans into a valid/ready request/response interface.

Parameters:
- IDCODE, 32'h249511C3, value captured by the IDCODE register (bit0 must be 1).
- ABITS, 7, DMI address width.
- IDLE_HINT, 1, value reported in the dtmcs.idle field.

Ports:
- clk_i  in  1  system clock; must run at ≥4× the TCK frequency.
- rst_i  in  1  synchronous active-high reset.
- jtag_tck_i  in  1  JTAG TCK, asynchronous.
- jtag_tms_i  in  1  JTAG TMS, asynchronous.
- jtag_tdi_i  in  1  JTAG TDI, asynchronous.
- jtag_trst_ni  in  1  JTAG TRST, active low, asynchronous.
- jtag_tdo_o  out  1  JTAG TDO.
- dmi_req_valid_o  out  1  DMI request valid.
- dmi_req_ready_i  in  1  DMI request accepted.
- dmi_req_addr_o  out  ABITS  DMI address.
- dmi_req_op_o  out  2  1 = read, 2 = write.
- dmi_req_data_o  out  32  DMI write data.
- dmi_rsp_valid_i  in  1  DMI response valid.
- dmi_rsp_ready_o  out  1  DMI response ready.
- dmi_rsp_data_i  in  32  DMI read data.
- dmi_rsp_resp_i  in  2  0 = ok, nonzero = failed.
- dmi_hardreset_o  out  1  one-cycle pulse on dtmcs.dmihardreset.

Behaviour:
- Input sampling
  - tck, tms, tdi and trst_n each pass through a 2-flop synchronizer, plus one history flop on tck.
  - TCK rising edge = sync 1 and previous 0; falling edge = the inverse.
  - All TAP activity happens only on these one-cycle strobes.
- Reset
  - rst_i, or synchronized trst_n == 0, forces the TAP to Test-Logic-Reset and IR = 5'h01.
  - rst_i additionally clears the DMI state: idle, sticky status 0, last addr 0, last data 0.
  - On rst_i all outputs are 0 (tdo, dmi_req_valid_o, dmi_hardreset_o, addr/op/data).
- TAP FSM
  - Standard 16-state IEEE 1149.1 machine, advanced on the TCK rising strobe using sampled tms.
  - Five consecutive TMS = 1 rising edges reach Test-Logic-Reset from any state.
  - Entering Test-Logic-Reset loads IR = 5'h01.
- IR
  - 5 bits.
  - Capture-IR loads 5'b00001.
  - Shift-IR shifts LSB-first, with TDI entering the MSB.
  - Update-IR latches the shifted value.
  - Decode: 0x01 IDCODE (32 b), 0x10 DTMCS (32 b), 0x11 DMI (ABITS+34 b), 0x1F and all others BYPASS (1 b).
- DR capture
  - IDCODE: captures IDCODE.
  - BYPASS: captures 0.
  - DTMCS captures:
    - [3:0] version = 1
    - [9:4] = ABITS
    - [11:10] = sticky dmistat
    - [14:12] = IDLE_HINT
    - all other bits 0
  - DMI captures {last_addr, last_data, op}, where op = 3 if a request is pending, else the sticky status.
- DR shift: LSB-first, TDI enters the MSB of the selected register length.
- DR update
  - DTMCS update:
    - bit16 (dmireset) clears the sticky status.
    - bit17 (dmihardreset) clears the sticky status, abandons the pending transaction and pulses dmi_hardreset_o for 1 clk.
  - DMI update with op 1 or 2 (shifted value {addr, data, op}):
    - If sticky status ≠ 0: ignored.
    - If busy: sticky status := 3, request ignored.
    - Otherwise: latch addr/data/op, assert dmi_req_valid_o.
  - DMI update with op 0 or 3: no action.
- TDO
  - Updated on the TCK falling strobe.
  - Shift-IR / Shift-DR: LSB of the active shift register.
  - Any other state: 0.
- DMI handshake
  - dmi_req_valid_o holds, with addr/op/data stable, until dmi_req_ready_i; it then drops the next clk.
  - dmi_rsp_ready_o = 1 while waiting for a response.
  - On dmi_rsp_valid_i: last_data := dmi_rsp_data_i for reads (writes keep the written data); last_addr := request addr.
  - Nonzero dmi_rsp_resp_i sets sticky status = 2; busy clears.
  - Busy spans from Update-DR until the response is received.
- Simultaneous events
  - Response and a new Update-DR in the same clk: the response is processed first, so the update is not busy.
  - trst or rst_i during a pending transaction: rst_i aborts it; trst only resets the TAP and the request completes normally.

Test Plan:
- rst_i, then 5×TMS = 1, go to Shift-DR without an IR scan, shift 32 bits -> TDO yields 0x249511C3 LSB-first.
- IR scan 0x10, shift DTMCS -> 0x00001071. A following IR scan shifts out 0b00001 as the captured IR.
- IR 0x1F, shift pattern 1,0,1,1 -> TDO echoes it delayed by one TCK, first bit 0.
- IR 0x11, DMI write addr 0x10 data 0x00000001 op 2 -> req_valid with those values; after ready and rsp (resp 0), the next DMI scan captures addr 0x10, data 0x1, op 0.
- DMI read issued while the response is withheld, second read update -> capture shows op 3; after the response the sticky reads 3; DTMCS write bit16 = 1 -> dmistat 0.
- Response with resp = 2 -> DMI capture op 2 and further requests ignored until dmireset. Pulling jtag_trst_ni low mid Shift-DR -> TAP in Test-Logic-Reset, IR = 0x01.
